// File: rtl/e_scan_controller_if.sv
// Bundle of request, plant-feedback and command signals for the SCAN
// elevator controller. The controller sits on the slave side; whatever
// produces requests and models the car plant sits on the master side.
//
// Handshake: there is no back-pressure anywhere. call_req bits are
// one-cycle pulses sampled on every clock. cab_req is taken only in a
// cycle where cab_valid=1. The controller always accepts, so there is no
// ready signal. All command outputs are registered and change one clock
// after the inputs that cause them.
interface e_scan_controller_if #(
    parameter int NUM_FLOORS = 6,
    parameter int LOC_W      = $clog2(NUM_FLOORS)
);
    logic [NUM_FLOORS-1:0] call_req;
    logic [NUM_FLOORS-1:0] cab_req;
    logic                  cab_valid;
    logic [LOC_W-1:0]      e_location;
    logic                  door_status;
    logic                  e_stop;
    logic                  up;
    logic                  down;
    logic                  stop;
    logic                  door_open;
    logic [NUM_FLOORS-1:0] pending;
    logic                  dir_up;
    logic [2:0]            e_state;

    modport slave (
        input  call_req, cab_req, cab_valid, e_location, door_status, e_stop,
        output up, down, stop, door_open, pending, dir_up, e_state
    );

    modport master (
        output call_req, cab_req, cab_valid, e_location, door_status, e_stop,
        input  up, down, stop, door_open, pending, dir_up, e_state
    );
endinterface

// File: rtl/e_scan_controller.sv
// Single-car SCAN elevator controller. Hall calls and cab requests are
// merged into a sticky pending bitmap. The car keeps its scan direction
// while requests remain ahead of it, and it serves every pending floor it
// passes. Each stop runs a timed door-open phase and then waits for the
// door to report closed. Emergency stop and an out-of-range location both
// force the HALT state. All outputs are Moore outputs, registered from the
// next state.
module e_scan_controller #(
    parameter int NUM_FLOORS  = 6,
    parameter int LOC_W       = $clog2(NUM_FLOORS),
    parameter int DOOR_CYCLES = 4
) (
    input logic                clk,
    input logic                rst_n,
    e_scan_controller_if.slave bus
);

    localparam int TMR_W   = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam int TMR_MAX = DOOR_CYCLES - 1;
    localparam int LIM     = NUM_FLOORS;
    localparam logic [TMR_W-1:0] TMR_LOAD  = TMR_MAX[TMR_W-1:0];
    localparam logic [LOC_W:0]   FLOOR_LIM = LIM[LOC_W:0];

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_MOVE_UP    = 3'd1,
        S_MOVE_DOWN  = 3'd2,
        S_DOOR_OPEN  = 3'd3,
        S_DOOR_CLOSE = 3'd4,
        S_HALT       = 3'd5
    } state_t;

    state_t                r_state;
    logic                  r_dir_up;
    logic [TMR_W-1:0]      r_timer;
    logic [NUM_FLOORS-1:0] r_pending;
    logic                  r_up;
    logic                  r_down;
    logic                  r_stop;
    logic                  r_door_open;

    state_t                w_next;
    logic                  w_dir_next;
    logic [TMR_W-1:0]      w_timer_next;
    logic [NUM_FLOORS-1:0] w_req;
    logic [NUM_FLOORS-1:0] w_loc_onehot;
    logic [NUM_FLOORS-1:0] w_clr;
    logic [NUM_FLOORS-1:0] w_pending_next;
    logic                  w_fault;
    logic                  w_hit;
    logic                  w_above;
    logic                  w_below;

    // Merge new requests with the sticky bitmap and locate them relative to the car.
    always_comb begin
        int loc_i;
        loc_i        = int'(bus.e_location);
        w_fault      = ({1'b0, bus.e_location} >= FLOOR_LIM);
        w_req        = r_pending | bus.call_req | (bus.cab_valid ? bus.cab_req : '0);
        w_loc_onehot = '0;
        w_above      = 1'b0;
        w_below      = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            w_loc_onehot[i] = (i == loc_i);
            if (i > loc_i) w_above = w_above | w_req[i];
            if (i < loc_i) w_below = w_below | w_req[i];
        end
        // An out-of-range location has an empty one-hot mask, so it never produces a hit.
        w_hit = |(w_req & w_loc_onehot);
    end

    // Next-state, scan direction and door timer decisions, in priority order.
    always_comb begin
        w_next       = r_state;
        w_dir_next   = r_dir_up;
        w_timer_next = r_timer;
        if (bus.e_stop || w_fault) begin
            w_next = S_HALT;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_hit) begin
                        w_next = S_DOOR_OPEN;
                    end else if (r_dir_up && w_above) begin
                        w_next = S_MOVE_UP;
                    end else if (w_below) begin
                        w_next     = S_MOVE_DOWN;
                        w_dir_next = 1'b0;
                    end else if (w_above) begin
                        w_next     = S_MOVE_UP;
                        w_dir_next = 1'b1;
                    end
                end
                S_MOVE_UP: begin
                    // Leaving with nothing ahead only happens if the plant overshoots.
                    if (w_hit)         w_next = S_DOOR_OPEN;
                    else if (!w_above) w_next = S_IDLE;
                end
                S_MOVE_DOWN: begin
                    if (w_hit)         w_next = S_DOOR_OPEN;
                    else if (!w_below) w_next = S_IDLE;
                end
                S_DOOR_OPEN: begin
                    // A fresh request for this floor keeps the door open for a full period.
                    if (w_hit)               w_timer_next = TMR_LOAD;
                    else if (r_timer == '0)  w_next       = S_DOOR_CLOSE;
                    else                     w_timer_next = r_timer - 1'b1;
                end
                S_DOOR_CLOSE: begin
                    if (bus.door_status) begin
                        if (w_hit) begin
                            w_next = S_DOOR_OPEN;
                        end else if (r_dir_up && w_above) begin
                            w_next = S_MOVE_UP;
                        end else if (!r_dir_up && w_below) begin
                            w_next = S_MOVE_DOWN;
                        end else if (w_above) begin
                            w_next     = S_MOVE_UP;
                            w_dir_next = 1'b1;
                        end else if (w_below) begin
                            w_next     = S_MOVE_DOWN;
                            w_dir_next = 1'b0;
                        end else begin
                            w_next = S_IDLE;
                        end
                    end
                end
                S_HALT:  w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
            if (w_next == S_DOOR_OPEN && r_state != S_DOOR_OPEN) begin
                w_timer_next = TMR_LOAD;
            end
        end
    end

    // Serve the current floor on entry to, or during, the open phase. A location fault freezes the bitmap.
    always_comb begin
        w_clr          = (w_next == S_DOOR_OPEN || r_state == S_DOOR_OPEN) ? w_loc_onehot : '0;
        w_pending_next = w_fault ? r_pending : (w_req & ~w_clr);
    end

    // State, bookkeeping and command outputs, all registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_dir_up    <= 1'b1;
            r_timer     <= '0;
            r_pending   <= '0;
            r_up        <= 1'b0;
            r_down      <= 1'b0;
            r_stop      <= 1'b1;
            r_door_open <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_dir_up    <= w_dir_next;
            r_timer     <= w_timer_next;
            r_pending   <= w_pending_next;
            r_up        <= (w_next == S_MOVE_UP);
            r_down      <= (w_next == S_MOVE_DOWN);
            r_stop      <= !(w_next == S_MOVE_UP || w_next == S_MOVE_DOWN);
            r_door_open <= (w_next == S_DOOR_OPEN);
        end
    end

    assign bus.up        = r_up;
    assign bus.down      = r_down;
    assign bus.stop      = r_stop;
    assign bus.door_open = r_door_open;
    assign bus.pending   = r_pending;
    assign bus.dir_up    = r_dir_up;
    assign bus.e_state   = r_state;

endmodule

// File: tb/tb_e_scan_controller.sv
// Bench for e_scan_controller. It includes a small car plant that moves one
// floor per cycle on up/down and closes the door whenever it is not
// commanded open, unless the door is being held. A scoreboard queues the
// floor order each scenario expects to be served. Each door_open rising
// edge pops that queue and compares the car location against the head.
module tb_e_scan_controller;
    localparam int NF = 6;
    localparam int LW = $clog2(NF);

    logic clk;
    logic rst_n;
    logic hold_open;
    int   n_pass;
    int   n_total;
    logic [LW-1:0] exp_q[$];
    logic prev_door;

    e_scan_controller_if #(.NUM_FLOORS(NF)) bus ();

    e_scan_controller #(.NUM_FLOORS(NF), .DOOR_CYCLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, wanted completion");
        $fatal(1);
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_door <= 1'b0;
        end else begin
            if (bus.door_open && !prev_door) begin
                n_total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL served_floor: served floor %0d, expected no service", bus.e_location);
                end else begin
                    logic [LW-1:0] e;
                    e = exp_q.pop_front();
                    if (bus.e_location !== e)
                        $display("FAIL served_floor: served floor %0d, expected floor %0d", bus.e_location, e);
                    else
                        n_pass++;
                end
            end
            prev_door <= bus.door_open;
        end
    end

    // ---------------- driver tasks ----------------
    // One clock, then the plant reacts to the freshly registered commands.
    task automatic step();
        @(posedge clk);
        #1;
        if (bus.up && bus.e_location < LW'(NF - 1))   bus.e_location = bus.e_location + LW'(1);
        if (bus.down && bus.e_location > LW'(0))      bus.e_location = bus.e_location - LW'(1);
        bus.door_status = hold_open ? 1'b0 : !bus.door_open;
    endtask

    task automatic pulse_call(input logic [NF-1:0] mask);
        bus.call_req = mask;
        step();
        bus.call_req = '0;
    endtask

    task automatic wait_door_open(input int budget);
        int k;
        k = 0;
        while (!bus.door_open && k < budget) begin
            step();
            k++;
        end
        n_total++;
        if (bus.door_open !== 1'b1) $display("FAIL door_open_timeout: door_open=%0b after %0d cycles, expected 1", bus.door_open, k);
        else n_pass++;
    endtask

    task automatic run_until_idle(input int budget);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (bus.e_state != 3'd0 && k < budget);
        n_total++;
        if (bus.e_state !== 3'd0) $display("FAIL idle_timeout: e_state=%0d after %0d cycles, expected 0", bus.e_state, k);
        else n_pass++;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        n_total++; if (bus.e_state !== 3'd0) $display("FAIL reset_state: got %0d expected 0", bus.e_state); else n_pass++;
        n_total++; if (bus.stop !== 1'b1) $display("FAIL reset_stop: got %0b expected 1", bus.stop); else n_pass++;
        n_total++; if ({bus.up, bus.down, bus.door_open} !== 3'b000) $display("FAIL reset_motion: up/down/door=%b expected 000", {bus.up, bus.down, bus.door_open}); else n_pass++;
        n_total++; if (bus.pending !== '0) $display("FAIL reset_pending: got %b expected 0", bus.pending); else n_pass++;
        n_total++; if (bus.dir_up !== 1'b1) $display("FAIL reset_dir: got %0b expected 1", bus.dir_up); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_up_scan();
        int n;
        bus.e_location = LW'(0);
        exp_q.push_back(LW'(2));
        exp_q.push_back(LW'(5));
        pulse_call(6'b100100);
        n_total++; if (bus.e_state !== 3'd1) $display("FAIL up_first_state: got %0d expected 1", bus.e_state); else n_pass++;
        n_total++; if (bus.pending !== 6'b100100) $display("FAIL up_first_pending: got %b expected 100100", bus.pending); else n_pass++;
        wait_door_open(20);
        n_total++; if (bus.e_location !== LW'(2)) $display("FAIL up_stop_floor: got %0d expected 2", bus.e_location); else n_pass++;
        n_total++; if (bus.pending !== 6'b100000) $display("FAIL up_stop_pending: got %b expected 100000", bus.pending); else n_pass++;
        n = 0;
        while (bus.door_open && n < 50) begin
            n++;
            step();
        end
        n_total++; if (n != 4) $display("FAIL up_door_cycles: got %0d expected 4", n); else n_pass++;
        run_until_idle(40);
        n_total++; if (bus.e_location !== LW'(5)) $display("FAIL up_end_floor: got %0d expected 5", bus.e_location); else n_pass++;
        n_total++; if (bus.pending !== '0) $display("FAIL up_end_pending: got %b expected 0", bus.pending); else n_pass++;
        n_total++; if (exp_q.size() != 0) $display("FAIL up_scoreboard: %0d floors left, expected 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_direction_hold();
        bus.e_location = LW'(1);
        bus.cab_req    = 6'b001000;
        bus.cab_valid  = 1'b0;
        step();
        bus.cab_req    = '0;
        n_total++; if (bus.pending !== '0) $display("FAIL cab_unqualified: pending got %b expected 0", bus.pending); else n_pass++;
        n_total++; if (bus.e_state !== 3'd0) $display("FAIL cab_unqualified_state: got %0d expected 0", bus.e_state); else n_pass++;
        exp_q.push_back(LW'(5));
        exp_q.push_back(LW'(0));
        pulse_call(6'b100000);
        bus.cab_req   = 6'b000001;
        bus.cab_valid = 1'b1;
        step();
        bus.cab_valid = 1'b0;
        bus.cab_req   = '0;
        n_total++; if (bus.pending !== 6'b100001) $display("FAIL hold_pending: got %b expected 100001", bus.pending); else n_pass++;
        n_total++; if (bus.e_state !== 3'd1) $display("FAIL hold_keeps_up: got %0d expected 1", bus.e_state); else n_pass++;
        wait_door_open(20);
        n_total++; if (bus.e_location !== LW'(5)) $display("FAIL hold_first_floor: got %0d expected 5", bus.e_location); else n_pass++;
        n_total++; if (bus.dir_up !== 1'b1) $display("FAIL hold_dir_at_top: got %0b expected 1", bus.dir_up); else n_pass++;
        run_until_idle(60);
        n_total++; if (bus.e_location !== LW'(0)) $display("FAIL hold_end_floor: got %0d expected 0", bus.e_location); else n_pass++;
        n_total++; if (bus.dir_up !== 1'b0) $display("FAIL hold_end_dir: got %0b expected 0", bus.dir_up); else n_pass++;
        n_total++; if (exp_q.size() != 0) $display("FAIL hold_scoreboard: %0d floors left, expected 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_down_scan();
        bus.e_location = LW'(5);
        exp_q.push_back(LW'(4));
        exp_q.push_back(LW'(2));
        exp_q.push_back(LW'(0));
        pulse_call(6'b010101);
        n_total++; if (bus.e_state !== 3'd2) $display("FAIL down_state: got %0d expected 2", bus.e_state); else n_pass++;
        n_total++; if (bus.down !== 1'b1 || bus.up !== 1'b0) $display("FAIL down_cmd: up/down=%b expected 01", {bus.up, bus.down}); else n_pass++;
        run_until_idle(80);
        n_total++; if (bus.pending !== '0) $display("FAIL down_end_pending: got %b expected 0", bus.pending); else n_pass++;
        n_total++; if (bus.dir_up !== 1'b0) $display("FAIL down_end_dir: got %0b expected 0", bus.dir_up); else n_pass++;
        n_total++; if (exp_q.size() != 0) $display("FAIL down_scoreboard: %0d floors left, expected 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_door_hold();
        int n;
        int g;
        bus.e_location = LW'(3);
        exp_q.push_back(LW'(3));
        pulse_call(6'b001000);
        n_total++; if (bus.e_state !== 3'd3) $display("FAIL door_same_floor_state: got %0d expected 3", bus.e_state); else n_pass++;
        n_total++; if ({bus.up, bus.down} !== 2'b00) $display("FAIL door_same_floor_motion: up/down=%b expected 00", {bus.up, bus.down}); else n_pass++;
        n_total++; if (bus.pending !== '0) $display("FAIL door_same_floor_pending: got %b expected 0", bus.pending); else n_pass++;
        n = 1;
        step();
        if (bus.door_open) n++;
        pulse_call(6'b001000);
        n_total++; if (bus.pending !== '0) $display("FAIL door_extend_pending: got %b expected 0", bus.pending); else n_pass++;
        if (bus.door_open) n++;
        hold_open = 1'b1;
        g = 0;
        while (bus.door_open && g < 30) begin
            step();
            g++;
            if (bus.door_open) n++;
        end
        n_total++; if (n != 6) $display("FAIL door_extend_cycles: got %0d expected 6", n); else n_pass++;
        repeat (5) step();
        n_total++; if (bus.e_state !== 3'd4) $display("FAIL door_held_state: got %0d expected 4", bus.e_state); else n_pass++;
        n_total++; if (bus.stop !== 1'b1 || bus.door_open !== 1'b0) $display("FAIL door_held_outputs: stop/door=%b expected 10", {bus.stop, bus.door_open}); else n_pass++;
        hold_open = 1'b0;
        run_until_idle(10);
        n_total++; if (exp_q.size() != 0) $display("FAIL door_scoreboard: %0d floors left, expected 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_estop();
        bus.e_location = LW'(0);
        pulse_call(6'b010000);
        n_total++; if (bus.e_state !== 3'd1) $display("FAIL estop_pre_state: got %0d expected 1", bus.e_state); else n_pass++;
        step();
        bus.e_stop = 1'b1;
        step();
        n_total++; if (bus.e_state !== 3'd5) $display("FAIL estop_halt_state: got %0d expected 5", bus.e_state); else n_pass++;
        n_total++; if (bus.up !== 1'b0 || bus.stop !== 1'b1) $display("FAIL estop_halt_outputs: up/stop=%b expected 01", {bus.up, bus.stop}); else n_pass++;
        n_total++; if (bus.pending !== 6'b010000) $display("FAIL estop_pending_kept: got %b expected 010000", bus.pending); else n_pass++;
        pulse_call(6'b000010);
        n_total++; if (bus.pending !== 6'b010010) $display("FAIL estop_new_call: got %b expected 010010", bus.pending); else n_pass++;
        repeat (3) step();
        n_total++; if (bus.e_state !== 3'd5) $display("FAIL estop_stays_halt: got %0d expected 5", bus.e_state); else n_pass++;
        exp_q.push_back(LW'(4));
        exp_q.push_back(LW'(1));
        bus.e_stop = 1'b0;
        step();
        n_total++; if (bus.e_state !== 3'd0) $display("FAIL estop_release_idle: got %0d expected 0", bus.e_state); else n_pass++;
        step();
        n_total++; if (bus.e_state !== 3'd1) $display("FAIL estop_resume_up: got %0d expected 1", bus.e_state); else n_pass++;
        run_until_idle(60);
        n_total++; if (bus.pending !== '0) $display("FAIL estop_end_pending: got %b expected 0", bus.pending); else n_pass++;
        n_total++; if (exp_q.size() != 0) $display("FAIL estop_scoreboard: %0d floors left, expected 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_location_fault();
        bus.e_location = LW'(7);
        pulse_call(6'b000100);
        n_total++; if (bus.e_state !== 3'd5) $display("FAIL fault_state: got %0d expected 5", bus.e_state); else n_pass++;
        n_total++; if ({bus.up, bus.down, bus.stop} !== 3'b001) $display("FAIL fault_outputs: up/down/stop=%b expected 001", {bus.up, bus.down, bus.stop}); else n_pass++;
        n_total++; if (bus.pending !== '0) $display("FAIL fault_pending: got %b expected 0", bus.pending); else n_pass++;
        bus.e_location = LW'(2);
        step();
        n_total++; if (bus.e_state !== 3'd0) $display("FAIL fault_recover: got %0d expected 0", bus.e_state); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bus.e_location = LW'(0);
        pulse_call(6'b100000);
        step();
        #3;
        rst_n = 1'b0;
        #1;
        n_total++; if (bus.e_state !== 3'd0) $display("FAIL midreset_state: got %0d expected 0", bus.e_state); else n_pass++;
        n_total++; if (bus.pending !== '0) $display("FAIL midreset_pending: got %b expected 0", bus.pending); else n_pass++;
        n_total++; if (bus.up !== 1'b0 || bus.stop !== 1'b1) $display("FAIL midreset_outputs: up/stop=%b expected 01", {bus.up, bus.stop}); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) step();
        n_total++; if (bus.e_state !== 3'd0) $display("FAIL midreset_lost: got %0d expected 0", bus.e_state); else n_pass++;
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        n_pass          = 0;
        n_total         = 0;
        hold_open       = 1'b0;
        rst_n           = 1'b0;
        bus.call_req    = '0;
        bus.cab_req     = '0;
        bus.cab_valid   = 1'b0;
        bus.e_location  = '0;
        bus.door_status = 1'b1;
        bus.e_stop      = 1'b0;
        test_reset();
        test_up_scan();
        test_direction_hold();
        test_down_scan();
        test_door_hold();
        test_estop();
        test_location_fault();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
